// File: rtl/weapon_mount.sv
// weapon_mount: weapon placement, facing and attack sequencing for the
// melee and archer weapon classes. Sits between the player/mouse control
// logic and the weapon/projectile draw and collision modules.
module weapon_mount #(
    parameter int W              = 12,
    parameter int MELEE_X_OFF    = 40,
    parameter int MELEE_Y_OFF    = 15,
    parameter int ARCHER_X_OFF   = 10,
    parameter int ARCHER_Y_OFF   = 12,
    parameter int PROJ_X_OFF     = 30,
    parameter int PROJ_Y_OFF     = -4,
    parameter int DEADBAND       = 2,
    parameter int SWING_STEPS    = 4,
    parameter int SWING_DX       = 4,
    parameter int FRAME_TICKS    = 4,
    parameter int COOLDOWN_TICKS = 8,
    parameter int SPAWN_STEP     = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         attack_req,
    input  logic         weapon_class,
    input  logic [W-1:0] pos_x,
    input  logic [W-1:0] pos_y,
    input  logic [W-1:0] mouse_x,
    output logic         attack_ack,
    output logic         busy,
    output logic         flip,
    output logic         active_class,
    output logic         hit_active,
    output logic         spawn,
    output logic [W-1:0] wpn_x,
    output logic [W-1:0] wpn_y,
    output logic [W-1:0] proj_x,
    output logic [W-1:0] proj_y
);

    localparam int STEP_W = (SWING_STEPS    > 1) ? $clog2(SWING_STEPS)    : 1;
    localparam int TICK_W = (FRAME_TICKS    > 1) ? $clog2(FRAME_TICKS)    : 1;
    localparam int CD_W   = (COOLDOWN_TICKS > 1) ? $clog2(COOLDOWN_TICKS) : 1;

    // Offsets reduced to W bits; negative values become their two's complement.
    localparam logic [W-1:0] LP_MX  = W'(MELEE_X_OFF);
    localparam logic [W-1:0] LP_MY  = W'(MELEE_Y_OFF);
    localparam logic [W-1:0] LP_AX  = W'(ARCHER_X_OFF);
    localparam logic [W-1:0] LP_AY  = W'(ARCHER_Y_OFF);
    localparam logic [W-1:0] LP_PX  = W'(PROJ_X_OFF);
    localparam logic [W-1:0] LP_PY  = W'(PROJ_Y_OFF);
    localparam logic [W:0]   LP_DB  = (W+1)'(DEADBAND);

    localparam logic [STEP_W-1:0] LP_STEP_LAST = STEP_W'(SWING_STEPS - 1);
    localparam logic [STEP_W-1:0] LP_SPAWN     = STEP_W'(SPAWN_STEP);
    localparam logic [TICK_W-1:0] LP_TICK_LAST = TICK_W'(FRAME_TICKS - 1);
    localparam logic [CD_W-1:0]   LP_CD_LAST   = CD_W'(COOLDOWN_TICKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWING,
        ST_COOLDOWN
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [STEP_W-1:0] r_step;
    logic [STEP_W-1:0] w_step_nxt;
    logic [TICK_W-1:0] r_tick;
    logic [TICK_W-1:0] w_tick_nxt;
    logic [CD_W-1:0]   r_cd;
    logic [CD_W-1:0]   w_cd_nxt;
    logic              w_accept;

    logic              r_ack;
    logic              r_flip;
    logic              r_active_class;
    logic [W-1:0]      r_wpn_x;
    logic [W-1:0]      r_wpn_y;
    logic [W-1:0]      r_proj_x;
    logic [W-1:0]      r_proj_y;

    logic              w_flip_nxt;
    logic              w_cls_eff;
    logic [W-1:0]      w_xoff;
    logic [W-1:0]      w_yoff;
    logic [W-1:0]      w_reach;
    logic [W-1:0]      w_xmag;
    logic [W:0]        w_mouse_ext;
    logic [W:0]        w_pos_ext;

    // State register and frame/cooldown counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_step  <= '0;
            r_tick  <= '0;
            r_cd    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_tick  <= w_tick_nxt;
            r_cd    <= w_cd_nxt;
        end
    end

    // Next-state logic: accept in IDLE, frame stepping in SWING, cooldown count.
    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_tick_nxt  = r_tick;
        w_cd_nxt    = r_cd;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (attack_req) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SWING;
                    w_step_nxt  = '0;
                    w_tick_nxt  = '0;
                    w_cd_nxt    = '0;
                end
            end
            ST_SWING: begin
                if (r_tick == LP_TICK_LAST) begin
                    w_tick_nxt = '0;
                    if (r_step == LP_STEP_LAST) begin
                        w_state_nxt = ST_COOLDOWN;
                        w_step_nxt  = '0;
                        w_cd_nxt    = '0;
                    end else begin
                        w_step_nxt = r_step + STEP_W'(1);
                    end
                end else begin
                    w_tick_nxt = r_tick + TICK_W'(1);
                end
            end
            ST_COOLDOWN: begin
                if (r_cd == LP_CD_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cd_nxt    = '0;
                end else begin
                    w_cd_nxt = r_cd + CD_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_step_nxt  = '0;
                w_tick_nxt  = '0;
                w_cd_nxt    = '0;
            end
        endcase
    end

    // State-decoded outputs; derived from flops so async reset clears them at once.
    always_comb begin
        busy       = (r_state != ST_IDLE);
        hit_active = (r_state == ST_SWING) && !r_active_class;
        spawn      = (r_state == ST_SWING) && r_active_class &&
                     (r_step == LP_SPAWN) && (r_tick == '0);
    end

    // Facing decision with deadband; compared one bit wider so edges never wrap.
    assign w_mouse_ext = {1'b0, mouse_x};
    assign w_pos_ext   = {1'b0, pos_x};

    always_comb begin
        w_flip_nxt = r_flip;
        if (w_mouse_ext > w_pos_ext + LP_DB) begin
            w_flip_nxt = 1'b0;
        end else if (w_mouse_ext + LP_DB < w_pos_ext) begin
            w_flip_nxt = 1'b1;
        end
    end

    // Offset selection: live class while idle, latched class during an attack.
    assign w_cls_eff = (r_state == ST_IDLE) ? weapon_class : r_active_class;
    assign w_xoff    = w_cls_eff ? LP_AX : LP_MX;
    assign w_yoff    = w_cls_eff ? LP_AY : LP_MY;
    assign w_reach   = ((r_state == ST_SWING) && !r_active_class) ?
                       W'(int'(r_step) * SWING_DX) : '0;
    assign w_xmag    = w_xoff + w_reach;

    // Latched attack attributes and registered sprite/projectile positions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack          <= 1'b0;
            r_flip         <= 1'b0;
            r_active_class <= 1'b0;
            r_wpn_x        <= '0;
            r_wpn_y        <= '0;
            r_proj_x       <= '0;
            r_proj_y       <= '0;
        end else begin
            r_ack <= w_accept;
            if (w_accept) begin
                r_flip         <= w_flip_nxt;
                r_active_class <= weapon_class;
            end
            r_wpn_x  <= r_flip ? (pos_x - w_xmag) : (pos_x + w_xmag);
            r_wpn_y  <= pos_y + w_yoff;
            r_proj_x <= r_flip ? (pos_x - LP_PX) : (pos_x + LP_PX);
            r_proj_y <= pos_y + LP_PY;
        end
    end

    assign attack_ack   = r_ack;
    assign flip         = r_flip;
    assign active_class = r_active_class;
    assign wpn_x        = r_wpn_x;
    assign wpn_y        = r_wpn_y;
    assign proj_x       = r_proj_x;
    assign proj_y       = r_proj_y;

endmodule

// File: tb/tb_weapon_mount.sv
// tb_weapon_mount: scoreboard bench for weapon_mount with a timeline-based
// reference model (attack phase = cycles since the accepting edge).
module tb_weapon_mount;

    localparam int W    = 12;
    localparam int MASK = (1 << W) - 1;
    localparam int MX = 40, MY = 15, AX = 10, AY = 12, PX = 30, PY = -4;
    localparam int DB = 2, S = 4, DX = 4, F = 4, C = 8, SP = 1;
    localparam int SW_LEN = S * F;
    localparam int TOT = S * F + C;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         attack_req = 1'b0;
    logic         weapon_class = 1'b0;
    logic [W-1:0] pos_x = '0;
    logic [W-1:0] pos_y = '0;
    logic [W-1:0] mouse_x = '0;
    logic         attack_ack, busy, flip, active_class, hit_active, spawn;
    logic [W-1:0] wpn_x, wpn_y, proj_x, proj_y;

    int checks = 0;
    int errors = 0;
    logic [53:0] exp_q[$];

    weapon_mount #(
        .W(W), .MELEE_X_OFF(MX), .MELEE_Y_OFF(MY), .ARCHER_X_OFF(AX),
        .ARCHER_Y_OFF(AY), .PROJ_X_OFF(PX), .PROJ_Y_OFF(PY), .DEADBAND(DB),
        .SWING_STEPS(S), .SWING_DX(DX), .FRAME_TICKS(F),
        .COOLDOWN_TICKS(C), .SPAWN_STEP(SP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .attack_req(attack_req),
        .weapon_class(weapon_class), .pos_x(pos_x), .pos_y(pos_y),
        .mouse_x(mouse_x), .attack_ack(attack_ack), .busy(busy), .flip(flip),
        .active_class(active_class), .hit_active(hit_active), .spawn(spawn),
        .wpn_x(wpn_x), .wpn_y(wpn_y), .proj_x(proj_x), .proj_y(proj_y)
    );

    always #5 clk = ~clk;

    function automatic logic [53:0] dut_outs();
        return {attack_ack, busy, flip, active_class, hit_active, spawn,
                wpn_x, wpn_y, proj_x, proj_y};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h @%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: evaluated at every rising edge with the inputs the DUT samples.
    initial begin : model
        int cyc, acc, op, np, reach, xo, yo, wx, wy, ppx, ppy;
        logic m_flip, m_cls, old_idle, cls_use, e_ack;
        logic [W-1:0] ewx, ewy, epx, epy;
        cyc = 0; acc = -100000; m_flip = 1'b0; m_cls = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                acc = -100000; m_flip = 1'b0; m_cls = 1'b0;
                exp_q.push_back('0);
            end else begin
                op       = cyc - 1 - acc;
                old_idle = (op >= TOT);
                cls_use  = old_idle ? weapon_class : m_cls;
                reach    = (!old_idle && op < SW_LEN && !m_cls) ? (op / F) * DX : 0;
                xo       = cls_use ? AX : MX;
                yo       = cls_use ? AY : MY;
                wx  = m_flip ? int'(pos_x) - (xo + reach) : int'(pos_x) + xo + reach;
                wy  = int'(pos_y) + yo;
                ppx = m_flip ? int'(pos_x) - PX : int'(pos_x) + PX;
                ppy = int'(pos_y) + PY;
                ewx = W'(wx & MASK); ewy = W'(wy & MASK);
                epx = W'(ppx & MASK); epy = W'(ppy & MASK);
                e_ack = 1'b0;
                if (old_idle && attack_req) begin
                    acc   = cyc;
                    e_ack = 1'b1;
                    m_cls = weapon_class;
                    if (int'(mouse_x) > int'(pos_x) + DB) m_flip = 1'b0;
                    else if (int'(mouse_x) + DB < int'(pos_x)) m_flip = 1'b1;
                end
                np = cyc - acc;
                exp_q.push_back({e_ack, (np < TOT), m_flip, m_cls,
                                 (np < SW_LEN) && !m_cls,
                                 (np < SW_LEN) && m_cls && (np == SP * F),
                                 ewx, ewy, epx, epy});
            end
        end
    end

    // Monitor: every cycle's outputs are compared against the oldest expectation.
    initial begin : monitor
        logic [53:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (dut_outs() !== e) begin
                    errors++;
                    $display("FAIL outputs{ack,busy,flip,cls,hit,spawn,wx,wy,px,py}: actual=%h expected=%h @%0t",
                             dut_outs(), e, $time);
                end
            end
        end
    end

    task automatic cyc_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic attack(input logic cls, input int px, input int py, input int mx);
        weapon_class = cls;
        pos_x = W'(px); pos_y = W'(py); mouse_x = W'(mx);
        attack_req = 1'b1;
        cyc_n(1);
        attack_req = 1'b0;
        cyc_n(TOT + 2);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin : stimulus
        int px;
        cyc_n(2);
        chk("reset_outputs", 64'(dut_outs()), 64'd0);
        rst_n = 1'b1;
        cyc_n(2);

        // Directed scenarios
        attack(1'b0, 300, 200, 400);          // melee facing right
        attack(1'b1, 300, 200, 100);          // archer facing left
        attack(1'b0, 300, 200, 301);          // inside deadband: stays left
        attack(1'b0, 300, 200, 303);          // turns right
        attack(1'b0, 300, 200, 299);          // inside deadband: stays right
        attack(1'b0, 300, 200, 297);          // turns left

        // Requests while busy are dropped
        weapon_class = 1'b0; mouse_x = 12'd400;
        attack_req = 1'b1; cyc_n(1); attack_req = 1'b0;
        cyc_n(6);
        attack_req = 1'b1; weapon_class = 1'b1; cyc_n(1); attack_req = 1'b0;
        cyc_n(12);
        attack_req = 1'b1; cyc_n(1); attack_req = 1'b0;
        cyc_n(10);

        // Held request: back-to-back accepts
        weapon_class = 1'b0;
        attack_req = 1'b1; cyc_n(3 * TOT + 5); attack_req = 1'b0;
        cyc_n(TOT + 2);

        // Modular wrap
        attack(1'b0, 10, 4090, 0);

        // Reset during archer step 0
        weapon_class = 1'b1; pos_x = 12'd300; pos_y = 12'd200; mouse_x = 12'd100;
        attack_req = 1'b1; cyc_n(1); attack_req = 1'b0;
        cyc_n(1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("reset_async_busy", 64'(busy), 64'd0);
        chk("reset_async_spawn", 64'(spawn), 64'd0);
        chk("reset_async_flip", 64'(flip), 64'd0);
        chk("reset_async_all", 64'(dut_outs()), 64'd0);
        cyc_n(3);
        rst_n = 1'b1;
        cyc_n(1);
        attack(1'b1, 300, 200, 100);

        // Randomized traffic
        repeat (1500) begin
            attack_req   = ($urandom_range(0, 9) < 3);
            weapon_class = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                px    = int'($urandom_range(0, 4093));
                pos_x = W'(px);
                pos_y = W'($urandom_range(0, 4095));
                if (px >= 4 && px < 4089 && $urandom_range(0, 1) == 1)
                    mouse_x = W'(px + int'($urandom_range(0, 8)) - 4);
                else
                    mouse_x = W'($urandom_range(0, 4093));
            end
            cyc_n(1);
        end
        attack_req = 1'b0;
        cyc_n(3);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/weapon_mount.md
# weapon_mount

Parametrised successor of the weapon positioning logic: one block serves melee and archer weapon classes, with per-class offsets, facing selection with a mouse deadband, and an attack sequencer. The sequencer animates the melee swing offset frame by frame, emits a one-cycle projectile spawn strobe for the archer class, and enforces a cooldown. It sits between the player/mouse control logic and the weapon/projectile draw and collision modules.

## Interface
Parameters:
- W, 12: coordinate width.
- MELEE_X_OFF, 40: melee horizontal offset from pos_x.
- MELEE_Y_OFF, 15: melee vertical offset.
- ARCHER_X_OFF, 10: bow horizontal offset.
- ARCHER_Y_OFF, 12: bow vertical offset.
- PROJ_X_OFF, 30: projectile spawn horizontal offset.
- PROJ_Y_OFF, -4: projectile spawn vertical offset (signed).
- DEADBAND, 2: mouse-to-player horizontal deadband, pixels.
- SWING_STEPS, 4: swing frames (≥1).
- SWING_DX, 4: extra melee reach per frame, pixels.
- FRAME_TICKS, 4: clock cycles per frame (≥1).
- COOLDOWN_TICKS, 8: cycles after swing before next accept (≥1).
- SPAWN_STEP, 1: archer frame on which the projectile spawns (< SWING_STEPS).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- attack_req  in  1  level request; sampled each cycle
- weapon_class  in  1  0 = melee, 1 = archer; latched on accept
- pos_x, pos_y  in  W  player position
- mouse_x  in  W  mouse x position
- attack_ack  out  1  one-cycle pulse: request accepted
- busy  out  1  high whenever the state is not IDLE
- flip  out  1  1 = facing left
- active_class  out  1  latched class
- hit_active  out  1  melee hitbox valid (melee, SWING state)
- spawn  out  1  one-cycle projectile spawn strobe
- wpn_x, wpn_y  out  W  weapon sprite position
- proj_x, proj_y  out  W  projectile spawn position

## Operation
- States: IDLE, SWING, COOLDOWN.
- IDLE with attack_req=1 → SWING.
  - Latch weapon_class into active_class.
  - Update flip: mouse_x > pos_x+DEADBAND → 0; mouse_x+DEADBAND < pos_x → 1; otherwise hold.
  - Reset step and tick to 0; pulse attack_ack.
- SWING: tick counts 0..FRAME_TICKS-1. On wrap, step increments. On wrap with step=SWING_STEPS-1 → COOLDOWN.
- COOLDOWN: counts COOLDOWN_TICKS cycles, then → IDLE.
- attack_req in SWING/COOLDOWN is ignored and not queued; no ack. A held request is re-accepted on the first IDLE cycle.
- weapon_class changes outside the IDLE→SWING transition have no effect on active_class.
- flip changes only on accept.
- Position outputs are registered and recomputed every cycle from the current pos inputs:
  - wpn_x = pos_x ± (XOFF + reach), where "−" applies when flip=1.
  - XOFF is the active class offset. reach = step·SWING_DX for melee in SWING, else 0.
  - wpn_y = pos_y + YOFF of the class.
  - proj_x = pos_x ± PROJ_X_OFF; proj_y = pos_y + PROJ_Y_OFF.
- Arithmetic: all sums are modulo 2^W (wrap, no saturation); signed offsets are sign-extended to W.
- hit_active = SWING ∧ active_class=0.
- spawn is 1 for exactly the first cycle with SWING ∧ active_class=1 ∧ step=SPAWN_STEP ∧ tick=0.
- In IDLE, offsets use weapon_class (live), so the idle sprite follows the selected class.

## Timing
- Reset (async assert, sync deassert handled upstream):
  - State IDLE; step and tick 0.
  - flip, active_class, attack_ack, busy, hit_active and spawn all 0.
  - wpn_x, wpn_y, proj_x and proj_y all 0.
- attack_req sampled high in IDLE at cycle N:
  - attack_ack, busy, SWING, step=0 are all valid at N+1.
  - SWING lasts SWING_STEPS·FRAME_TICKS cycles; COOLDOWN lasts COOLDOWN_TICKS cycles.
  - busy falls at N+1+SWING_STEPS·FRAME_TICKS+COOLDOWN_TICKS.
  - Earliest next accept is sampled at that cycle.
- Position outputs: 1-cycle latency from pos_x/pos_y/mouse-driven flip.
- spawn occurs at N+1+SPAWN_STEP·FRAME_TICKS.
- Reset asserted mid-SWING: all outputs return to reset values immediately (combinationally via the async flop reset); no spawn is emitted.

## Test plan
- Melee, right: pos=(300,200), mouse_x=400, class 0, req at N.
  - ack at N+1, flip=0.
  - wpn_x = 340/344/348/352, each held 4 cycles; wpn_y=215; hit_active for 16 cycles.
  - busy for 24 cycles; spawn never.
- Archer, left: pos=(300,200), mouse_x=100, class 1.
  - flip=1, wpn=(290,212), proj=(270,196).
  - spawn single pulse at N+5; hit_active stays 0.
- Deadband: flip=1, pos_x=300.
  - mouse_x=301 → flip stays 1; mouse_x=303 → flip 0.
  - mouse_x=299 → stays 0; mouse_x=297 → flip 1.
- Busy rejection:
  - Pulse req mid-SWING and mid-COOLDOWN → no ack, no restart.
  - Hold req high continuously → acks spaced exactly 25 cycles apart.
- Wrap: pos_x=10, mouse_x=0, melee → wpn_x=4066 (W=12). pos_y=4090, melee → wpn_y=9.
- Reset mid-op: assert rst_n=0 during archer step 0 → busy/spawn/flip 0 immediately; after release, a new req is accepted normally.
